mem_access: RTL and testbench



---
 rtl/rv32_pkg.sv | 11 +
 rtl/load_align.sv | 18 +
 rtl/mem_access.sv | 117 +++++++++++
 tb/tb_mem_access.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcode/funct3 constants and memory-stage state encoding shared by the rv32 pipeline.
package rv32_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_WAIT} mem_state_e;
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    data_o = f3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
             f3_i == F3_BU ? {24'h0, sh[7:0]} :
             f3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
             f3_i == F3_HU ? {16'h0, sh[15:0]} : rdata_i;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: rv32 memory-access stage; issues loads/stores over a req/gnt/rvalid port and registers results for writeback.
module mem_access
  import rv32_pkg::*;
#(
  parameter int          DMEM_AW   = 32,
  parameter logic [31:0] RST_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        in_instruction,
  input  logic [31:0]        in_alu_result,
  input  logic [31:0]        in_rs2_data,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [31:0]        dmem_rdata,
  output logic               out_valid,
  output logic [31:0]        out_instruction,
  output logic [31:0]        out_alu_result,
  output logic [31:0]        out_load_data,
  output logic               out_exc
);
  mem_state_e  state_q;
  logic [31:0] instr_q, alu_q, wdata_q, wdata_d, ld_data;
  logic [3:0]  be_q, be_d;
  logic        we_q;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic        is_ld, is_st, f3_ok, mis, bad;
  always_comb begin
    op    = in_instruction[6:0];
    f3    = in_instruction[14:12];
    a     = in_alu_result[1:0];
    is_ld = op == OP_LOAD;
    is_st = op == OP_STORE;
    f3_ok = (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (is_ld && (f3 == F3_BU || f3 == F3_HU));
    mis   = ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
    bad   = (is_ld || is_st) && (!f3_ok || mis);
    be_d  = is_st && f3 == F3_B ? 4'b0001 << a :
            is_st && f3 == F3_H ? 4'b0011 << a : 4'b1111;
    wdata_d = f3 == F3_B ? {4{in_rs2_data[7:0]}} :
              f3 == F3_H ? {2{in_rs2_data[15:0]}} : in_rs2_data;
  end
  assign stall      = state_q != MEM_IDLE;
  assign dmem_req   = state_q == MEM_REQ;
  assign dmem_we    = we_q;
  assign dmem_addr  = {alu_q[DMEM_AW-1:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  load_align u_align (
    .rdata_i(dmem_rdata),
    .off_i  (alu_q[1:0]),
    .f3_i   (instr_q[14:12]),
    .data_o (ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= MEM_IDLE;
      instr_q         <= '0;
      alu_q           <= '0;
      be_q            <= '0;
      wdata_q         <= '0;
      we_q            <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= RST_INSTR;
      out_alu_result  <= '0;
      out_load_data   <= '0;
      out_exc         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        MEM_IDLE: if (in_valid) begin
          if ((is_ld || is_st) && !bad) begin
            state_q <= MEM_REQ;
            instr_q <= in_instruction;
            alu_q   <= in_alu_result;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= is_st;
          end else begin
            out_valid       <= 1'b1;
            out_instruction <= in_instruction;
            out_alu_result  <= in_alu_result;
            out_load_data   <= '0;
            out_exc         <= bad;
          end
        end
        MEM_REQ: if (dmem_gnt) begin
          state_q <= we_q ? MEM_IDLE : MEM_WAIT;
          if (we_q) begin
            out_valid       <= 1'b1;
            out_instruction <= instr_q;
            out_alu_result  <= alu_q;
            out_load_data   <= '0;
            out_exc         <= 1'b0;
          end
        end
        MEM_WAIT: if (dmem_rvalid) begin
          state_q         <= MEM_IDLE;
          out_valid       <= 1'b1;
          out_instruction <= instr_q;
          out_alu_result  <= alu_q;
          out_load_data   <= ld_data;
          out_exc         <= 1'b0;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed test-plan cases plus randomized traffic checked every cycle against a transaction-level model.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst, in_valid, dmem_gnt, dmem_rvalid;
  logic [31:0] in_instruction, in_alu_result, in_rs2_data, dmem_rdata;
  logic        stall, dmem_req, dmem_we, out_valid, out_exc;
  logic [31:0] dmem_addr, dmem_wdata, out_instruction, out_alu_result, out_load_data;
  logic [3:0]  dmem_be;
  int checks = 0, errors = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_instruction(out_instruction),
    .out_alu_result(out_alu_result), .out_load_data(out_load_data), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  bit          busy, granted, accepted;
  logic [31:0] t_instr, t_alu, t_wdata;
  logic [3:0]  t_be;
  bit          t_we;
  bit          e_valid, e_exc;
  logic [31:0] e_instr, e_alu, e_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [31:0] addr, input logic [2:0] f3);
    int size;
    logic [31:0] mask, v;
    size = 1 << f3[1:0];
    mask = size == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    v = (rdata >> (8 * addr[1:0])) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic retire(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] ld, input bit exc);
    e_valid = 1; e_instr = ins; e_alu = alu; e_ld = ld; e_exc = exc;
  endtask

  task automatic model_edge();
    logic [6:0] op;
    logic [2:0] f3;
    bit ld, st, legal;
    int size, off;
    accepted = 0;
    if (rst) begin
      busy = 0; granted = 0;
      e_valid = 0; e_instr = 32'h0; e_alu = 0; e_ld = 0; e_exc = 0;
      return;
    end
    e_valid = 0;
    if (!busy) begin
      if (in_valid) begin
        accepted = 1;
        op = in_instruction[6:0];
        f3 = in_instruction[14:12];
        ld = op == 7'b0000011;
        st = op == 7'b0100011;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size = 1 << f3[1:0];
        off = int'(in_alu_result[1:0]);
        if (!ld && !st) retire(in_instruction, in_alu_result, 0, 0);
        else if (!legal || (off % size) != 0) retire(in_instruction, in_alu_result, 0, 1);
        else begin
          busy = 1; granted = 0;
          t_instr = in_instruction; t_alu = in_alu_result; t_we = st;
          for (int i = 0; i < 4; i++) begin
            t_be[i] = ld || (i >= off && i < off + size);
            t_wdata[8*i +: 8] = in_rs2_data[8*(i % size) +: 8];
          end
        end
      end
    end else if (!granted) begin
      if (dmem_gnt) begin
        if (t_we) begin retire(t_instr, t_alu, 0, 0); busy = 0; end
        else granted = 1;
      end
    end else if (dmem_rvalid) begin
      retire(t_instr, t_alu, extract(dmem_rdata, t_alu, t_instr[14:12]), 0);
      busy = 0;
    end
  endtask

  task automatic compare();
    chk("stall", 32'(stall), 32'(busy));
    chk("dmem_req", 32'(dmem_req), 32'(busy && !granted));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_instruction", out_instruction, e_instr);
    chk("out_alu_result", out_alu_result, e_alu);
    chk("out_load_data", out_load_data, e_ld);
    chk("out_exc", 32'(out_exc), 32'(e_exc));
    if (busy && !granted) begin
      chk("dmem_addr", dmem_addr, {t_alu[31:2], 2'b00});
      chk("dmem_be", 32'(dmem_be), 32'(t_be));
      chk("dmem_we", 32'(dmem_we), 32'(t_we));
      if (t_we) chk("dmem_wdata", dmem_wdata, t_wdata);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2);
    in_valid = v; in_instruction = ins; in_alu_result = alu; in_rs2_data = rs2;
  endtask

  localparam logic [31:0] ADD = 32'h002081B3, SW = 32'h0020A223, SB = 32'h00208023;
  localparam logic [31:0] LB = 32'h00008183, LBU = 32'h0000C183, LH = 32'h00009183, LW = 32'h0000A183;

  initial begin
    bit held;
    logic [6:0] op;
    rst = 1; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    step();
    chk("reset out_instruction", out_instruction, 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset dmem_req", 32'(dmem_req), 32'h0);
    rst = 0;
    step();
    drive(1, ADD, 32'h1234, 0);
    step();
    drive(0, ADD, 32'h1234, 0);
    chk("add valid", 32'(out_valid), 32'h1);
    chk("add alu", out_alu_result, 32'h1234);
    chk("add stall", 32'(stall), 32'h0);
    drive(1, SW, 32'h104, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("sw addr", dmem_addr, 32'h104);
      chk("sw be", 32'(dmem_be), 32'hF);
      chk("sw wdata", dmem_wdata, 32'hDEADBEEF);
      chk("sw stall", 32'(stall), 32'h1);
      step();
    end
    chk("sw stall 4th", 32'(stall), 32'h1);
    dmem_gnt = 1;
    step();
    dmem_gnt = 0;
    chk("sw valid", 32'(out_valid), 32'h1);
    chk("sw stall after", 32'(stall), 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(1, k == 0 ? LB : LBU, 32'h203, 0);
      step();
      drive(0, 0, 0, 0);
      dmem_gnt = 1;
      step();
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000;
      chk("ld wait req", 32'(dmem_req), 32'h0);
      step();
      dmem_rvalid = 0;
      chk(k == 0 ? "lb data" : "lbu data", out_load_data, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
    end
    drive(1, LH, 32'h201, 0);
    step();
    drive(0, 0, 0, 0);
    chk("lh mis valid", 32'(out_valid), 32'h1);
    chk("lh mis exc", 32'(out_exc), 32'h1);
    chk("lh mis req", 32'(dmem_req), 32'h0);
    drive(1, SB, 32'h102, 32'hAB);
    step();
    drive(0, 0, 0, 0);
    chk("sb be", 32'(dmem_be), 32'h4);
    chk("sb wdata", dmem_wdata, 32'hABABABAB);
    dmem_gnt = 1;
    step();
    dmem_gnt = 0;
    drive(1, LW, 32'h300, 0);
    step();
    drive(0, 0, 0, 0);
    dmem_gnt = 1;
    step();
    dmem_gnt = 0; rst = 1;
    step();
    rst = 0; dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    step();
    dmem_rvalid = 0;
    chk("rst mid valid", 32'(out_valid), 32'h0);
    chk("rst mid req", 32'(dmem_req), 32'h0);
    chk("rst mid stall", 32'(stall), 32'h0);
    drive(1, LW, 32'h400, 0);
    step();
    drive(1, ADD, 32'h55, 0);
    dmem_gnt = 1;
    step();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 0;
    chk("b2b lw valid", 32'(out_valid), 32'h1);
    chk("b2b lw instr", out_instruction, LW);
    chk("b2b lw data", out_load_data, 32'hCAFE_F00D);
    step();
    drive(0, 0, 0, 0);
    chk("b2b add valid", 32'(out_valid), 32'h1);
    chk("b2b add instr", out_instruction, ADD);
    step();
    chk("b2b no dup", 32'(out_valid), 32'h0);
    held = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!held) begin
        case ($urandom_range(0, 3))
          0: op = 7'b0000011;
          1: op = 7'b0100011;
          2: op = 7'b0110011;
          default: op = 7'($urandom);
        endcase
        drive($urandom_range(0, 2) != 0, {17'($urandom), 3'($urandom), 5'($urandom), op}, $urandom, $urandom);
      end
      rst = $urandom_range(0, 99) < 2;
      dmem_gnt = $urandom_range(0, 9) < 4;
      dmem_rvalid = $urandom_range(0, 9) < 4;
      dmem_rdata = $urandom;
      model_edge();
      held = in_valid && !accepted;
      @(posedge clk);
      @(negedge clk);
      compare();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
